// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode/completion bundle between pipeline and hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int LAT_W = 3
);
    logic             issueValid;
    logic [4:0]       issueRd;
    logic             issueRegWrite;
    logic             issueLong;
    logic [LAT_W-1:0] issueLat;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             rs1Used;
    logic             rs2Used;
    logic             cplValid;
    logic [4:0]       cplRd;
    logic             flush;
    logic             stall;
    logic [5:0]       pendingCount;
    logic             cplErr;

    // Pipeline side: drives decode, completion and flush; consumes stall and status
    modport master (
        output issueValid, issueRd, issueRegWrite, issueLong, issueLat,
        output rs1, rs2, rs1Used, rs2Used, cplValid, cplRd, flush,
        input  stall, pendingCount, cplErr
    );

    // Scoreboard side
    modport slave (
        input  issueValid, issueRd, issueRegWrite, issueLong, issueLat,
        input  rs1, rs2, rs1Used, rs2Used, cplValid, cplRd, flush,
        output stall, pendingCount, cplErr
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight register write tracker raising the decode stall
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int LAT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave sb
);
    // Entry 0 exists only for uniform indexing; it is forced empty so x0 costs nothing.
    logic [NREG-1:0]  pend_q, pend_d;
    logic [NREG-1:0]  long_q, long_d;
    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];
    logic [5:0]       count_q, count_d;
    logic             err_q, err_d;

    logic [NREG-1:0]  rdy;
    logic             stall_c;
    logic             accept;
    logic             cpl_bad;

    // Per-register readiness: empty, fixed op forwarding this cycle, or long op completing now
    always_comb begin
        rdy = '0;
        for (int i = 0; i < NREG; i++) begin
            rdy[i] = !pend_q[i]
                   | (!long_q[i] && cnt_q[i] == LAT_W'(1))
                   | (long_q[i] && sb.cplValid && sb.cplRd == 5'(i));
        end
        rdy[0] = 1'b1;
    end

    // Stall on RAW for used sources and on WAW for the destination
    always_comb begin
        stall_c = sb.issueValid & ((sb.rs1Used & !rdy[sb.rs1])
                                 | (sb.rs2Used & !rdy[sb.rs2])
                                 | (sb.issueRegWrite & !rdy[sb.issueRd]));
        // A flush squashes the decoding instruction, so nothing is accepted alongside it
        accept  = sb.issueValid & !stall_c & sb.issueRegWrite & (sb.issueRd != 5'd0)
                & (sb.issueLong | (sb.issueLat != '0)) & !sb.flush;
        cpl_bad = sb.cplValid & ((sb.cplRd == 5'd0)
                | !(pend_q[sb.cplRd] & long_q[sb.cplRd]));
    end

    // Next entry state: countdown, completion, flush, then accept overrides all
    always_comb begin
        pend_d  = pend_q;
        long_d  = long_q;
        count_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pend_q[i] && !long_q[i]) begin
                cnt_d[i] = cnt_q[i] - LAT_W'(1);
                if (cnt_q[i] == LAT_W'(1)) begin
                    pend_d[i] = 1'b0;
                end
            end
            if (pend_q[i] && long_q[i] && sb.cplValid && sb.cplRd == 5'(i)) begin
                pend_d[i] = 1'b0;
            end
            if (sb.flush && !long_q[i]) begin
                pend_d[i] = 1'b0;
            end
            if (accept && sb.issueRd == 5'(i)) begin
                pend_d[i] = 1'b1;
                long_d[i] = sb.issueLong;
                cnt_d[i]  = sb.issueLat;
            end
            if (!pend_d[i] || i == 0) begin
                pend_d[i] = 1'b0;
                long_d[i] = 1'b0;
                cnt_d[i]  = '0;
            end
            count_d = count_d + 6'(pend_d[i]);
        end
        err_d = err_q | cpl_bad;
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            long_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pend_q  <= pend_d;
            long_q  <= long_d;
            count_q <= count_d;
            err_q   <= err_d;
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Drive outputs
    always_comb begin
        sb.stall        = stall_c;
        sb.pendingCount = count_q;
        sb.cplErr       = err_q;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector bench for hazard_scoreboard
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.LAT_W(3)) sbif ();

    hazard_scoreboard #(.NREG(32), .LAT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbif.slave)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [4:0] rd;
        logic       rw;
        logic       lng;
        logic [2:0] lat;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic       cv;
        logic [4:0] crd;
        logic       fl;
        logic       e_stall;
        int         e_cnt;
        logic       e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, input logic iv, input logic [4:0] rd,
                                input logic rw, input logic lng, input logic [2:0] lat,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic u1, input logic u2, input logic cv,
                                input logic [4:0] crd, input logic fl,
                                input logic es, input int ec, input logic ee);
        vec_t v;
        v.rst = rst; v.iv = iv; v.rd = rd; v.rw = rw; v.lng = lng; v.lat = lat;
        v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2; v.cv = cv; v.crd = crd; v.fl = fl;
        v.e_stall = es; v.e_cnt = ec; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset              = v.rst;
        sbif.issueValid    = v.iv;
        sbif.issueRd       = v.rd;
        sbif.issueRegWrite = v.rw;
        sbif.issueLong     = v.lng;
        sbif.issueLat      = v.lat;
        sbif.rs1           = v.r1;
        sbif.rs2           = v.r2;
        sbif.rs1Used       = v.u1;
        sbif.rs2Used       = v.u2;
        sbif.cplValid      = v.cv;
        sbif.cplRd         = v.crd;
        sbif.flush         = v.fl;
    endtask

    initial begin
        int stalls;
        logic done;
        drive(mk(1,0,0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0));

        //           rst iv rd rw lg lat r1 r2 u1 u2 cv crd fl  stall cnt err
        // reset
        vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
        // load-use on long rd5
        vq.push_back(mk(0, 1, 5, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  5, 0, 1, 0, 0, 0, 0,  1, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  5, 0, 1, 0, 0, 0, 0,  1, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  5, 0, 1, 0, 0, 0, 0,  1, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  5, 0, 1, 0, 1, 5, 0,  0, 0, 0));
        // fixed latency 3 on rd7, consumer via rs2
        vq.push_back(mk(0, 1, 7, 1, 0, 3,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  0, 7, 0, 1, 0, 0, 0,  1, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  0, 7, 0, 1, 0, 0, 0,  1, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  0, 7, 0, 1, 0, 0, 0,  0, 0, 0));
        // latency 1 producer never stalls its consumer
        vq.push_back(mk(0, 1,10, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 10, 0, 1, 0, 0, 0, 0,  0, 0, 0));
        // x0 and unused operands
        vq.push_back(mk(0, 1, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
        vq.push_back(mk(0, 1, 0, 1, 0, 0,  0, 0, 1, 1, 0, 0, 0,  0, 0, 0));
        vq.push_back(mk(0, 1, 9, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  9, 0, 0, 0, 0, 0, 0,  0, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 9, 0,  0, 0, 0));
        // WAW: long rd4 pending, fixed rd4 lat2 waits for completion then takes over
        vq.push_back(mk(0, 1, 4, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0));
        vq.push_back(mk(0, 1, 4, 1, 0, 2,  0, 0, 0, 0, 0, 0, 0,  1, 1, 0));
        vq.push_back(mk(0, 1, 4, 1, 0, 2,  0, 0, 0, 0, 0, 0, 0,  1, 1, 0));
        vq.push_back(mk(0, 1, 4, 1, 0, 2,  0, 0, 0, 0, 1, 4, 0,  0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  4, 0, 1, 0, 0, 0, 0,  1, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  4, 0, 1, 0, 0, 0, 0,  0, 0, 0));
        // flush keeps long rd6, drops fixed rd3 and a same-cycle accept of rd11
        vq.push_back(mk(0, 1, 6, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0));
        vq.push_back(mk(0, 1, 3, 1, 0, 3,  0, 0, 0, 0, 0, 0, 0,  0, 2, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 2, 0));
        vq.push_back(mk(0, 1,11, 1, 0, 2,  0, 0, 0, 0, 0, 0, 1,  0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  3, 6, 1, 0, 0, 0, 0,  0, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  6, 0, 1, 0, 0, 0, 0,  1, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 11, 0, 1, 0, 0, 0, 0,  0, 1, 0));
        // spurious completion is sticky
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 8, 0,  0, 1, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 1, 1));
        // reset with three entries pending
        vq.push_back(mk(0, 1,12, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0,  0, 2, 1));
        vq.push_back(mk(0, 1,13, 1, 0, 4,  0, 0, 0, 0, 0, 0, 0,  0, 3, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 0,  6,12, 1, 1, 0, 0, 0,  0, 0, 0));
        // completion to x0 is an error
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0,  0, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0));

        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k]);
            #1;
            chk($sformatf("stall[%0d]", k), int'(sbif.stall), int'(vq[k].e_stall));
            @(posedge clk);
            #1;
            chk($sformatf("count[%0d]", k), int'(sbif.pendingCount), vq[k].e_cnt);
            chk($sformatf("err[%0d]", k), int'(sbif.cplErr), int'(vq[k].e_err));
        end

        // Maximum fixed latency: consumer stalls exactly 6 cycles
        @(negedge clk);
        drive(mk(0, 1,15, 1, 0, 7,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
        #1;
        chk("lat7_issue_stall", int'(sbif.stall), 0);
        @(posedge clk);
        stalls = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            drive(mk(0, 1, 0, 0, 0, 0, 15, 0, 1, 0, 0, 0, 0,  0, 0, 0));
            #1;
            if (!sbif.stall) done = 1'b1;
            else stalls++;
            @(posedge clk);
        end
        chk("lat7_done", int'(done), 1);
        chk("lat7_stalls", stalls, 6);
        #1;
        chk("lat7_count", int'(sbif.pendingCount), 0);

        // Flush in the same cycle as a long completion empties the board without error
        @(negedge clk);
        drive(mk(0, 1,20, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        drive(mk(0, 1,21, 1, 0, 5,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
        @(posedge clk);
        #1;
        chk("fc_count_before", int'(sbif.pendingCount), 2);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,20, 1,  0, 0, 0));
        @(posedge clk);
        #1;
        chk("fc_count_after", int'(sbif.pendingCount), 0);
        chk("fc_err", int'(sbif.cplErr), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
